adder_share_ctrl: RTL and testbench
===================================

Name: adder_share_ctrl

Overview:
- Controller that shares one ripple-carry propagate/generate adder (SWR bits, carry register between bits 25 and 26 when SWR>26) between two requesters in the natural-logarithm datapath.
- Arbitrates round-robin, registers operands and holds them stable for the full adder latency, and captures the low and high sum halves in the correct cycles.
- Returns one tagged result (sum, carry-out, propagate vector) over a valid/ready handshake.

Parameters:
- SWR, 26, adder width; legal range 26..52.
- SPLIT, 26, bit position of the adder's internal carry register; fixed at 26, not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid_i  in  1  requester 0 has an operation.
- req0_ready_o  out  1  requester 0 operation accepted this cycle.
- req0_op_a_i  in  SWR  requester 0 operand A.
- req0_op_b_i  in  SWR  requester 0 operand B.
- req0_sub_i  in  1  requester 0: 1 = A-B, 0 = A+B.
- req1_valid_i, req1_ready_o, req1_op_a_i, req1_op_b_i, req1_sub_i: same as requester 0.
- add_op_a_o  out  SWR  adder operand A.
- add_op_b_o  out  SWR  adder operand B (already inverted for subtract).
- add_c_o  out  1  adder carry-in.
- add_s_i  in  SWR  adder sum.
- add_c_i  in  1  adder carry-out.
- add_p_i  in  SWR  adder propagate vector.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer accepts result.
- res_id_o  out  1  requester index of the result.
- res_sum_o  out  SWR  captured sum.
- res_cout_o  out  1  captured carry-out.
- res_p_o  out  SWR  captured propagate vector.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs, operand registers and result registers clear to 0.
  - last_grant is set to 1, so requester 0 wins the first tie.
- States: IDLE, EXEC_LO, EXEC_HI, DONE. EXEC_HI exists only when SWR>26.
- IDLE:
  - reqN_ready_o = grant[N] and no other condition; ready is 0 in every other state.
  - Grant goes to the sole valid requester. If both are valid, grant goes to the requester not equal to last_grant.
  - On accept: register A; register B, or ~B when sub=1; register carry-in = sub; register id; update last_grant; go to EXEC_LO.
- add_op_a_o, add_op_b_o and add_c_o come straight from the operand registers and stay stable through EXEC_LO and EXEC_HI.
- EXEC_LO, end of cycle:
  - Capture add_s_i[25:0] and add_p_i[25:0].
  - If SWR=26: also capture add_c_i, then go to DONE.
  - Otherwise go to EXEC_HI. The adder's internal carry register loads carry(26) on this same edge.
- EXEC_HI, end of cycle: capture add_s_i[SWR-1:26], add_p_i[SWR-1:26] and add_c_i, then go to DONE.
- DONE:
  - res_valid_o=1; all result fields held stable.
  - On res_valid_o & res_ready_i, go to IDLE; res_valid_o drops the next cycle.
- Latency from the accept edge to res_valid_o=1: 2 cycles (SWR=26), 3 cycles (SWR>26).
- Throughput: one operation per 3 cycles (SWR=26) or 4 cycles (SWR>26) with res_ready_i held at 1. No overlap of operations.
- Backpressure: DONE is held indefinitely and no new accept occurs. Pending requesters simply wait; valid is not required to stay asserted.
- Subtract is two's complement: res_cout_o=1 means A>=B (no borrow). Widths are never extended; overflow is reported only through res_cout_o.
- A requester that deasserts valid before being granted is dropped with no side effect.
- Reset mid-operation aborts the in-flight operation; nothing is reported for it.

Decomposition:
- Shared package holds:
  - state enum (IDLE=2'd0, EXEC_LO=2'd1, EXEC_HI=2'd2, DONE=2'd3);
  - constant ADD_SPLIT=26;
  - result-record typedef {id, cout, sum, p}.
- One sub-module, rr_arb2: two-input round-robin arbiter with last_grant state, enable input, grant output.

Test Plan:
- SWR=26; req0 add A=0x0000005, B=0x0000003 -> accept at cycle k; at k+2 res_valid=1, sum=0x0000008, cout=0, id=0, p=0x0000006.
- SWR=26; req1 sub A=0x0000005, B=0x0000003 -> add_op_b_o=0x3FFFFFC, add_c_o=1; result sum=0x0000002, cout=1, id=1.
- SWR=30; req0 add A=0x03FFFFFF, B=0x00000001 -> low half captured in EXEC_LO, valid at k+3; sum=0x04000000, cout=0.
- Both valid from the first cycle after reset with res_ready=1 -> req0 served first, then req1; ready pulses one cycle each, one grant per operation.
- res_ready=0 for 5 cycles in DONE -> res_* stable, both ready_o=0; on res_ready=1, IDLE next cycle and the next accept follows.
- rst asserted during EXEC_HI (SWR=30) -> res_valid=0 and all outputs 0 immediately; after release, a fresh req0 add 1+1 yields sum=0x2 at k+3.

Source files
------------

// File: rtl/adder_share_ctrl_pkg.sv
// Shared types and constants for the shared-adder controller of the
// natural-logarithm datapath.
package adder_share_ctrl_pkg;

  // Controller phases; EXEC_HI is only visited when the adder is wider than
  // its internal carry-register split point.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC_LO = 2'd1,
    EXEC_HI = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Bit position of the carry register inside the shared ripple adder.
  localparam int ADD_SPLIT = 26;

  // Widest adder the controller supports; sizes the result record.
  localparam int SWR_MAX = 52;

  // One returned result, sized for the widest adder (narrower adders
  // zero-extend sum and p).
  typedef struct packed {
    logic               id;
    logic               cout;
    logic [SWR_MAX-1:0] sum;
    logic [SWR_MAX-1:0] p;
  } result_t;

endpackage

// File: rtl/adder_share_ctrl_arb.sv
// Two-input round-robin arbiter. When both inputs request, the one that was
// not granted last wins; last_grant resets to 1 so input 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_grant;

  // Combinational grant: sole requester wins, ties go to the other side.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        grant = last_grant ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

  // Remember who was served so the next tie alternates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (grant != 2'b00) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one ripple propagate/generate adder between two requesters.
// Operands are registered at accept and held for the whole adder latency;
// the low sum half is captured after the first execute cycle and, for adders
// wider than the carry-register split, the high half one cycle later.
module adder_share_ctrl
  import adder_share_ctrl_pkg::*;
#(
  parameter int SWR   = 26,
  parameter int SPLIT = 26
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid_i,
  output logic           req0_ready_o,
  input  logic [SWR-1:0] req0_op_a_i,
  input  logic [SWR-1:0] req0_op_b_i,
  input  logic           req0_sub_i,
  input  logic           req1_valid_i,
  output logic           req1_ready_o,
  input  logic [SWR-1:0] req1_op_a_i,
  input  logic [SWR-1:0] req1_op_b_i,
  input  logic           req1_sub_i,
  output logic [SWR-1:0] add_op_a_o,
  output logic [SWR-1:0] add_op_b_o,
  output logic           add_c_o,
  input  logic [SWR-1:0] add_s_i,
  input  logic           add_c_i,
  input  logic [SWR-1:0] add_p_i,
  output logic           res_valid_o,
  input  logic           res_ready_i,
  output logic           res_id_o,
  output logic [SWR-1:0] res_sum_o,
  output logic           res_cout_o,
  output logic [SWR-1:0] res_p_o
);

  // A high half exists only when the adder extends past its carry register.
  localparam bit HAS_HI = (SWR > ADD_SPLIT);
  // Selects the bits below the carry register (all bits when SWR == SPLIT).
  localparam logic [SWR-1:0] LO_MASK = {SWR{1'b1}} >> (SWR - SPLIT);

  state_t         state;
  logic [1:0]     grant;
  logic           arb_en;
  logic [SWR-1:0] sel_a;
  logic [SWR-1:0] sel_b;
  logic           sel_sub;
  logic [SWR-1:0] op_a;
  logic [SWR-1:0] op_b;
  logic           cin;
  logic           id;
  logic           res_valid;
  logic           res_cout;
  logic [SWR-1:0] res_sum;
  logic [SWR-1:0] res_p;

  // Arbitration is only open in IDLE and never while reset is held.
  assign arb_en = rst && (state == IDLE);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .req   ({req1_valid_i, req0_valid_i}),
    .grant (grant)
  );

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];

  assign add_op_a_o  = op_a;
  assign add_op_b_o  = op_b;
  assign add_c_o     = cin;
  assign res_valid_o = res_valid;
  assign res_id_o    = id;
  assign res_sum_o   = res_sum;
  assign res_cout_o  = res_cout;
  assign res_p_o     = res_p;

  // Operand mux driven by the winning requester.
  always_comb begin
    sel_a   = grant[1] ? req1_op_a_i : req0_op_a_i;
    sel_b   = grant[1] ? req1_op_b_i : req0_op_b_i;
    sel_sub = grant[1] ? req1_sub_i  : req0_sub_i;
  end

  // Controller FSM: accept, hold operands through execute, capture halves, hand off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      cin       <= 1'b0;
      id        <= 1'b0;
      res_valid <= 1'b0;
      res_cout  <= 1'b0;
      res_sum   <= '0;
      res_p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            op_a  <= sel_a;
            op_b  <= sel_sub ? ~sel_b : sel_b;
            cin   <= sel_sub;
            id    <= grant[1];
            state <= EXEC_LO;
          end
        end
        EXEC_LO: begin
          res_sum <= (res_sum & ~LO_MASK) | (add_s_i & LO_MASK);
          res_p   <= (res_p & ~LO_MASK) | (add_p_i & LO_MASK);
          if (HAS_HI) begin
            // The adder latches carry(26) on this edge; high half is valid next cycle.
            state <= EXEC_HI;
          end else begin
            res_cout  <= add_c_i;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        EXEC_HI: begin
          res_sum   <= (res_sum & LO_MASK) | (add_s_i & ~LO_MASK);
          res_p     <= (res_p & LO_MASK) | (add_p_i & ~LO_MASK);
          res_cout  <= add_c_i;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready_i) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl: one instance with a 26-bit adder and one with a
// 30-bit adder (carry register between bits 25 and 26), each fed by a
// behavioural adder model and checked by a scoreboard monitor.
module tb_adder_share_ctrl;
  import adder_share_ctrl_pkg::*;

  localparam int W = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  // Stimulus, indexed [instance][requester]
  logic [1:0][1:0]        valid;
  logic [1:0][1:0][W-1:0] op_a;
  logic [1:0][1:0][W-1:0] op_b;
  logic [1:0][1:0]        sub;
  logic [1:0]             res_ready;

  // Observed DUT outputs, zero-extended to W, indexed [instance]
  logic [1:0][1:0]   ready_v;
  logic [1:0]        rvalid;
  logic [1:0]        rid;
  logic [1:0]        rcout;
  logic [1:0]        addc;
  logic [1:0][W-1:0] rsum;
  logic [1:0][W-1:0] rp;
  logic [1:0][W-1:0] adda;
  logic [1:0][W-1:0] addb;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int SW  = (g == 0) ? 26 : 30;
    localparam int LAT = (SW > 26) ? 3 : 2;
    localparam logic [W-1:0] MASK = W'((64'd1 << SW) - 64'd1);

    logic [SW-1:0] a_w, b_w, s_w, p_w, sum_w, rp_w;
    logic          c_in_w, cout_w, rdy0, rdy1, rv, rd, rc;

    adder_share_ctrl #(.SWR(SW), .SPLIT(26)) dut (
      .clk          (clk),
      .rst          (rst),
      .req0_valid_i (valid[g][0]),
      .req0_ready_o (rdy0),
      .req0_op_a_i  (op_a[g][0][SW-1:0]),
      .req0_op_b_i  (op_b[g][0][SW-1:0]),
      .req0_sub_i   (sub[g][0]),
      .req1_valid_i (valid[g][1]),
      .req1_ready_o (rdy1),
      .req1_op_a_i  (op_a[g][1][SW-1:0]),
      .req1_op_b_i  (op_b[g][1][SW-1:0]),
      .req1_sub_i   (sub[g][1]),
      .add_op_a_o   (a_w),
      .add_op_b_o   (b_w),
      .add_c_o      (c_in_w),
      .add_s_i      (s_w),
      .add_c_i      (cout_w),
      .add_p_i      (p_w),
      .res_valid_o  (rv),
      .res_ready_i  (res_ready[g]),
      .res_id_o     (rd),
      .res_sum_o    (sum_w),
      .res_cout_o   (rc),
      .res_p_o      (rp_w)
    );

    assign ready_v[g] = {rdy1, rdy0};
    assign rvalid[g]  = rv;
    assign rid[g]     = rd;
    assign rcout[g]   = rc;
    assign addc[g]    = c_in_w;
    assign rsum[g]    = W'(sum_w);
    assign rp[g]      = W'(rp_w);
    assign adda[g]    = W'(a_w);
    assign addb[g]    = W'(b_w);

    // Shared adder model: low 26 bits combinational, carry(26) registered.
    logic [26:0] lo;
    logic        creg;
    assign p_w = a_w ^ b_w;
    assign lo  = {1'b0, a_w[25:0]} + {1'b0, b_w[25:0]} + 27'(c_in_w);
    always @(posedge clk) creg <= lo[26];
    if (SW > 26) begin : g_hi
      logic [SW-26:0] hi;
      assign hi     = {1'b0, a_w[SW-1:26]} + {1'b0, b_w[SW-1:26]} + (SW-25)'(creg);
      assign s_w    = {hi[SW-27:0], lo[25:0]};
      assign cout_w = hi[SW-26];
    end else begin : g_flat
      assign s_w    = lo[25:0];
      assign cout_w = lo[26];
    end

    // Reference result from plain arithmetic on the requested operation.
    function automatic result_t model(input logic rid_in, input logic [W-1:0] a_in,
                                      input logic [W-1:0] b_in, input logic s);
      longint unsigned a, b, m, r;
      result_t e;
      m = (64'd1 << SW) - 64'd1;
      a = 64'(a_in) & m;
      b = 64'(b_in) & m;
      e = '0;
      e.id = rid_in;
      if (s) begin
        r      = (a - b) & m;
        e.cout = (a >= b);
        e.p    = SWR_MAX'((a ^ ~b) & m);
      end else begin
        r      = a + b;
        e.cout = (r > m);
        r      = r & m;
        e.p    = SWR_MAX'(a ^ b);
      end
      e.sum = SWR_MAX'(r);
      return e;
    endfunction

    result_t        q[$];
    logic           busy = 1'b0;
    logic           last = 1'b1;
    int             acc = 0;
    logic [W-1:0]   xa, xb;
    logic           xc;
    logic [W-1:0]   last_sum, last_p;
    logic           last_cout, last_id;

    // Monitor: checks grants, operand hold, latency and results each cycle.
    always @(negedge clk) begin
      logic [1:0] exp_rdy;
      logic       r;
      result_t    e;
      if (!rst) begin
        q.delete();
        busy = 1'b0;
        last = 1'b1;
      end else begin
        exp_rdy = 2'b00;
        if (!busy) begin
          if (valid[g] == 2'b11) exp_rdy = last ? 2'b01 : 2'b10;
          else                   exp_rdy = valid[g];
        end
        check($sformatf("ready_i%0d", g), 64'(ready_v[g]), 64'(exp_rdy));
        check($sformatf("res_valid_i%0d", g), 64'(rvalid[g]), 64'(busy && (cyc - acc >= LAT)));
        if (busy && cyc > acc) begin
          check($sformatf("add_op_a_i%0d", g), 64'(adda[g]), 64'(xa));
          check($sformatf("add_op_b_i%0d", g), 64'(addb[g]), 64'(xb));
          check($sformatf("add_c_i%0d", g), 64'(addc[g]), 64'(xc));
        end
        if (rvalid[g]) begin
          if (q.size() == 0) begin
            check($sformatf("unexpected_result_i%0d", g), 64'(rvalid[g]), 64'd0);
          end else begin
            e = q[0];
            check($sformatf("res_id_i%0d", g), 64'(rid[g]), 64'(e.id));
            check($sformatf("res_sum_i%0d", g), 64'(rsum[g]), 64'(e.sum));
            check($sformatf("res_cout_i%0d", g), 64'(rcout[g]), 64'(e.cout));
            check($sformatf("res_p_i%0d", g), 64'(rp[g]), 64'(e.p));
            if (res_ready[g]) begin
              last_sum  = rsum[g];
              last_p    = rp[g];
              last_cout = rcout[g];
              last_id   = rid[g];
              void'(q.pop_front());
              busy = 1'b0;
            end
          end
        end
        if (exp_rdy != 2'b00) begin
          r = exp_rdy[1];
          q.push_back(model(r, op_a[g][r], op_b[g][r], sub[g][r]));
          xa   = op_a[g][r] & MASK;
          xb   = (sub[g][r] ? ~op_b[g][r] : op_b[g][r]) & MASK;
          xc   = sub[g][r];
          busy = 1'b1;
          acc  = cyc;
          last = r;
        end
      end
    end
  end

  task automatic set_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    for (int g = 0; g < 2; g++) begin
      op_a[g][r] = a;
      op_b[g][r] = b;
      sub[g][r]  = s;
    end
  endtask

  // Hold valid on the requested requesters of both instances until accepted.
  task automatic run_ops(input logic [1:0] want);
    logic [1:0][1:0] pend;
    pend  = {want, want};
    valid = pend;
    for (int c = 0; c < 60 && pend != '0; c++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++)
        for (int r = 0; r < 2; r++)
          if (pend[g][r] && ready_v[g][r]) pend[g][r] = 1'b0;
      @(posedge clk);
      #1;
      valid = pend;
    end
    check("accept_timeout", 64'(pend), 64'd0);
    valid = '0;
  endtask

  task automatic drain();
    int c = 0;
    while ((g_inst[0].busy || g_inst[1].busy) && c < 200) begin
      @(posedge clk);
      c++;
    end
    check("drain_timeout", 64'({g_inst[1].busy, g_inst[0].busy}), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_ready_i%0d", tag, g), 64'(ready_v[g]), 64'd0);
      check($sformatf("%s_valid_i%0d", tag, g), 64'(rvalid[g]), 64'd0);
      check($sformatf("%s_id_i%0d", tag, g), 64'(rid[g]), 64'd0);
      check($sformatf("%s_cout_i%0d", tag, g), 64'(rcout[g]), 64'd0);
      check($sformatf("%s_sum_i%0d", tag, g), 64'(rsum[g]), 64'd0);
      check($sformatf("%s_p_i%0d", tag, g), 64'(rp[g]), 64'd0);
      check($sformatf("%s_opa_i%0d", tag, g), 64'(adda[g]), 64'd0);
      check($sformatf("%s_opb_i%0d", tag, g), 64'(addb[g]), 64'd0);
      check($sformatf("%s_cin_i%0d", tag, g), 64'(addc[g]), 64'd0);
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [63:0] x;
    x = {$urandom(), $urandom()};
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(1) << $urandom_range(0, W - 1);
      default: return x[W-1:0];
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    valid     = '0;
    op_a      = '0;
    op_b      = '0;
    sub       = '0;
    res_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");

    // Both requesters valid from the first cycle after reset: req0 then req1.
    set_op(0, 30'h0000_1234, 30'h0000_0101, 1'b0);
    set_op(1, 30'h0000_0200, 30'h0000_0300, 1'b1);
    valid = '1;
    rst   = 1'b1;
    run_ops(2'b11);
    drain();
    check("tie_order_last_id_i0", 64'(g_inst[0].last_id), 64'd1);
    check("tie_order_last_id_i1", 64'(g_inst[1].last_id), 64'd1);

    // req0 add 5+3
    set_op(0, 30'd5, 30'd3, 1'b0);
    run_ops(2'b01);
    drain();
    check("add53_sum", 64'(g_inst[0].last_sum), 64'h8);
    check("add53_cout", 64'(g_inst[0].last_cout), 64'h0);
    check("add53_id", 64'(g_inst[0].last_id), 64'h0);
    check("add53_p", 64'(g_inst[0].last_p), 64'h6);

    // req1 subtract 5-3
    set_op(1, 30'd5, 30'd3, 1'b1);
    run_ops(2'b10);
    check("sub53_opb", 64'(addb[0]), 64'h3FF_FFFC);
    check("sub53_cin", 64'(addc[0]), 64'h1);
    drain();
    check("sub53_sum", 64'(g_inst[0].last_sum), 64'h2);
    check("sub53_cout", 64'(g_inst[0].last_cout), 64'h1);
    check("sub53_id", 64'(g_inst[0].last_id), 64'h1);

    // Carry crossing the split point (30-bit) / full wrap (26-bit)
    set_op(0, 30'h03FF_FFFF, 30'h1, 1'b0);
    run_ops(2'b01);
    drain();
    check("split_sum_w30", 64'(g_inst[1].last_sum), 64'h0400_0000);
    check("split_cout_w30", 64'(g_inst[1].last_cout), 64'h0);
    check("wrap_sum_w26", 64'(g_inst[0].last_sum), 64'h0);
    check("wrap_cout_w26", 64'(g_inst[0].last_cout), 64'h1);

    // Backpressure: result held in DONE while another request waits
    res_ready = 2'b00;
    set_op(0, rnd_op(), rnd_op(), 1'b1);
    run_ops(2'b01);
    set_op(1, rnd_op(), rnd_op(), 1'b0);
    valid = {2'b10, 2'b10};
    repeat (8) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("stall_valid_i%0d", g), 64'(rvalid[g]), 64'd1);
      check($sformatf("stall_ready_i%0d", g), 64'(ready_v[g]), 64'd0);
    end
    res_ready = 2'b11;
    run_ops(2'b10);
    drain();

    // Reset while the 30-bit instance is in EXEC_HI
    set_op(0, rnd_op(), rnd_op(), 1'b0);
    run_ops(2'b01);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_zero("midreset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_op(0, 30'd1, 30'd1, 1'b0);
    run_ops(2'b01);
    drain();
    check("post_reset_sum_w30", 64'(g_inst[1].last_sum), 64'h2);
    check("post_reset_sum_w26", 64'(g_inst[0].last_sum), 64'h2);

    // Randomized traffic with dropped requests and random backpressure
    for (int i = 0; i < 800; i++) begin
      for (int g = 0; g < 2; g++) begin
        for (int r = 0; r < 2; r++) begin
          valid[g][r] = ($urandom_range(0, 99) < 55);
          op_a[g][r]  = rnd_op();
          op_b[g][r]  = rnd_op();
          sub[g][r]   = $urandom_range(0, 1);
        end
        res_ready[g] = ($urandom_range(0, 99) < 70);
      end
      @(posedge clk);
      #1;
    end
    valid     = '0;
    res_ready = 2'b11;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
